multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. Takes the 11-bit opcode from the instruction parser plus the ALU zero flag, and steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and handshakes with instruction and data memories that may insert wait states. It also counts retired instructions and halts on an unsupported opcode.

---
 rtl/legv8_pkg.sv | 40 ++++
 rtl/op_classify.sv | 25 ++
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode encodings, FSM states, ALU op and opcode classes.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'd1986;
  localparam logic [10:0] OP_STUR = 11'd1984;
  localparam logic [10:0] OP_ADD  = 11'd1112;
  localparam logic [10:0] OP_SUB  = 11'd1624;
  localparam logic [10:0] OP_AND  = 11'd1104;
  localparam logic [10:0] OP_ORR  = 11'd1360;

  // Prefix matches on opcode[10:3] and opcode[10:5]
  localparam logic [7:0] OP_CBZ_PFX = 8'hB4;
  localparam logic [5:0] OP_B_PFX   = 6'b000101;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StBranch,
    StHalt
  } ctrl_state_t;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluPassB = 2'b01,
    AluFunct = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ClsR,
    ClsLd,
    ClsSt,
    ClsCbz,
    ClsB,
    ClsIll
  } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: maps the 11-bit LEGv8 opcode onto an instruction class.
module op_classify
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    op_class = ClsIll;
    if (opcode == OP_LDUR) begin
      op_class = ClsLd;
    end else if (opcode == OP_STUR) begin
      op_class = ClsSt;
    end else if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND ||
                 opcode == OP_ORR) begin
      op_class = ClsR;
    end else if (opcode[10:3] == OP_CBZ_PFX) begin
      op_class = ClsCbz;
    end else if (opcode[10:5] == OP_B_PFX) begin
      op_class = ClsB;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: FSM, captured opcode class and retired-instruction counter.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         opcode,
  input  logic                alu_zero,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2_loc,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  ctrl_state_t         state_q, state_d;
  op_class_t           cls_q, cls_live;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;
  alu_op_t             alu_op_w;

  op_classify u_op_classify (
    .opcode   (opcode),
    .op_class (cls_live)
  );

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    alu_op_w   = AluAdd;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2_loc   = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    // Outputs stay quiet while reset is held so requests drop without waiting for a clock
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          reg2_loc = (cls_live == ClsSt) || (cls_live == ClsCbz);
          unique case (cls_live)
            ClsR, ClsLd, ClsSt: state_d = StExec;
            ClsCbz, ClsB:       state_d = StBranch;
            default:            state_d = StHalt;
          endcase
        end
        StExec: begin
          if (cls_q == ClsR) begin
            alu_op_w = AluFunct;
            state_d  = StWb;
          end else begin
            alu_src = 1'b1;
            state_d = StMem;
          end
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == ClsSt);
          if (dmem_ack) begin
            if (cls_q == ClsSt) begin
              retire  = 1'b1;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == ClsLd);
          retire     = 1'b1;
          state_d    = StFetch;
        end
        StBranch: begin
          retire  = 1'b1;
          state_d = StFetch;
          if (cls_q == ClsB) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end else begin
            alu_op_w = AluPassB;
            reg2_loc = 1'b1;
            pc_write = alu_zero;
            pc_src   = alu_zero;
          end
        end
        StHalt: halted = 1'b1;
        default: state_d = StHalt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsIll;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        cls_q <= cls_live;
      end
      if (retire) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  assign alu_op  = alu_op_w;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int RW = 4;

  localparam logic [10:0] LDUR = 11'd1986;
  localparam logic [10:0] STUR = 11'd1984;
  localparam logic [10:0] ADD  = 11'd1112;
  localparam logic [10:0] CBZ  = 11'h5A0;
  localparam logic [10:0] BUNC = 11'h0A0;
  localparam logic [10:0] ILL  = 11'd0;

  typedef struct packed {
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          reg2_loc;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic          mem_to_reg;
    logic          reg_write;
    logic          halted;
    logic [RW-1:0] retired;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   opcode;
  logic          alu_zero, imem_ack, dmem_ack;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic          reg2_loc, alu_src, mem_to_reg, reg_write, halted;
  logic [1:0]    alu_op;
  logic [RW-1:0] retired;

  vec_t          exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [RW-1:0] r = '0;

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg2_loc   (reg2_loc),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational on state + ack, so sample mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        vec_t  e;
        vec_t  g;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        g = '{imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg2_loc, alu_src,
              alu_op, mem_to_reg, reg_write, halted, retired};
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got %b want %b (imr dmr we irw pcw pcs r2l asrc aop m2r rw hlt ret)",
                   t, $time, g, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t v0(input logic [RW-1:0] ret);
    vec_t v;
    v = '0;
    v.retired = ret;
    return v;
  endfunction

  task automatic step(input string tag, input logic ia, input logic da, input logic az,
                      input vec_t e);
    imem_ack = ia;
    dmem_ack = da;
    alu_zero = az;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input int waits, input logic [10:0] op);
    vec_t v;
    for (int i = 0; i < waits; i++) begin
      v = v0(r);
      v.imem_req = 1'b1;
      step({tag, "/fetch_wait"}, 1'b0, 1'b1, 1'b0, v);
    end
    opcode = op;
    v = v0(r);
    v.imem_req = 1'b1;
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    step({tag, "/fetch"}, 1'b1, 1'b0, 1'b0, v);
  endtask

  // Opcode is scrambled after DECODE to prove the class was captured
  task automatic decode(input string tag, input logic r2l);
    vec_t v;
    v = v0(r);
    v.reg2_loc = r2l;
    step({tag, "/decode"}, 1'b0, 1'b0, 1'b0, v);
    opcode = 11'h7FF;
  endtask

  task automatic run_r(input string tag);
    vec_t v;
    fetch(tag, 0, ADD);
    decode(tag, 1'b0);
    v = v0(r);
    v.alu_op = 2'b10;
    step({tag, "/exec"}, 1'b0, 1'b1, 1'b1, v);
    v = v0(r);
    v.reg_write = 1'b1;
    step({tag, "/wb"}, 1'b1, 1'b0, 1'b0, v);
    r = r + 1'b1;
  endtask

  task automatic run_mem(input string tag, input logic is_st, input int dw);
    vec_t v;
    fetch(tag, 0, is_st ? STUR : LDUR);
    decode(tag, is_st);
    v = v0(r);
    v.alu_src = 1'b1;
    step({tag, "/exec"}, 1'b0, 1'b0, 1'b1, v);
    for (int i = 0; i <= dw; i++) begin
      v = v0(r);
      v.dmem_req = 1'b1;
      v.dmem_we  = is_st;
      step({tag, "/mem"}, 1'b1, (i == dw), 1'b0, v);
    end
    if (!is_st) begin
      v = v0(r);
      v.reg_write  = 1'b1;
      v.mem_to_reg = 1'b1;
      step({tag, "/wb"}, 1'b0, 1'b0, 1'b0, v);
    end
    r = r + 1'b1;
  endtask

  task automatic run_br(input string tag, input logic [10:0] op, input logic is_cbz,
                        input logic az, input int fw);
    vec_t v;
    fetch(tag, fw, op);
    decode(tag, is_cbz);
    v = v0(r);
    if (is_cbz) begin
      v.alu_op   = 2'b01;
      v.reg2_loc = 1'b1;
      v.pc_write = az;
      v.pc_src   = az;
    end else begin
      v.pc_write = 1'b1;
      v.pc_src   = 1'b1;
    end
    step({tag, "/branch"}, 1'b0, 1'b0, az, v);
    r = r + 1'b1;
  endtask

  initial begin
    vec_t v;
    rst_n    = 1'b0;
    opcode   = '0;
    alu_zero = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b1, 1'b0, v0('0));
    rst_n = 1'b1;

    run_mem("ldur", 1'b0, 0);
    run_r("add");
    run_mem("stur_wait3", 1'b1, 3);
    run_br("cbz_taken", CBZ, 1'b1, 1'b1, 1);
    run_br("cbz_not", CBZ, 1'b1, 1'b0, 0);
    run_br("b", BUNC, 1'b0, 1'b0, 0);

    // Reset during an LDUR memory wait: request drops at once, ack in reset is lost
    fetch("ld_abort", 0, LDUR);
    decode("ld_abort", 1'b0);
    v = v0(r);
    v.alu_src = 1'b1;
    step("ld_abort/exec", 1'b0, 1'b0, 1'b0, v);
    v = v0(r);
    v.dmem_req = 1'b1;
    step("ld_abort/mem_wait", 1'b0, 1'b0, 1'b0, v);
    rst_n = 1'b0;
    r = '0;
    step("ld_abort/in_reset", 1'b1, 1'b1, 1'b0, v0(r));
    step("ld_abort/in_reset2", 1'b1, 1'b1, 1'b0, v0(r));
    rst_n = 1'b1;

    // 19 R-type retires from 0: counter wraps through 0 at 16 and ends at 3
    for (int i = 0; i < 19; i++) begin
      run_r("add_wrap");
    end

    fetch("illegal", 0, ILL);
    decode("illegal", 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = v0(r);
      v.halted = 1'b1;
      opcode = (i % 2 == 0) ? ADD : LDUR;
      step("halt", i[0], i[1], 1'b1, v);
    end
    rst_n = 1'b0;
    r = '0;
    step("halt/reset", 1'b1, 1'b0, 1'b0, v0(r));
    rst_n = 1'b1;
    run_r("add_after_halt");
    v = v0(r);
    v.imem_req = 1'b1;
    step("final_fetch_wait", 1'b0, 1'b0, 1'b0, v);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
